// File: rtl/codec_intf.sv
// I2S-style codec interface: clock/reset generation, ADC deserialiser, DAC serialiser. Optional CODEC_LOOPBACK_EN adds lpbk.
// Latency: ADC pair out at cnt 0x010 (valid at 0x011) one frame after capture; DAC pair loaded at cnt 0x01F, shifted on SCLK falls.
// Backpressure: none; fixed frame timing, core must accept the valid strobe and hold lft_in/rht_in around the load clk.
module codec_intf #(
    parameter logic [9:0] CNT_RST     = 10'h200,
    parameter int         RSTN_FRAMES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef CODEC_LOOPBACK_EN
    input  logic        lpbk,
`endif
    input  logic [15:0] lft_in,
    input  logic [15:0] rht_in,
    input  logic        SDout,
    output logic [15:0] lft_out,
    output logic [15:0] rht_out,
    output logic        valid,
    output logic        LRCLK,
    output logic        SCLK,
    output logic        MCLK,
    output logic        RSTn,
    output logic        SDin
);

    localparam int FW = (RSTN_FRAMES > 1) ? $clog2(RSTN_FRAMES) : 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_CODEC_RST,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [FW-1:0]  r_frm;
    logic [FW-1:0]  w_frm_nxt;
    logic [9:0]     r_cnt;
    logic [31:0]    r_rx_shft;
    logic [31:0]    r_tx_shft;
    logic [15:0]    r_lft;
    logic [15:0]    r_rht;
    logic           r_valid;
    logic           r_rstn;

    logic           w_wrap;
    logic           w_sclk_rise;
    logic           w_sclk_fall;
    logic           w_tx_load;
    logic           w_capture;
    logic           w_rx_bit;

    assign w_wrap      = (r_cnt == 10'h3FF);
    assign w_sclk_rise = (r_cnt[4:0] == 5'h0F);
    assign w_sclk_fall = (r_cnt[4:0] == 5'h1F);
    assign w_tx_load   = (r_cnt == 10'h01F);
    assign w_capture   = (r_cnt == 10'h010);

`ifdef CODEC_LOOPBACK_EN
    assign w_rx_bit = lpbk ? r_tx_shft[31] : SDout;
`else
    assign w_rx_bit = SDout;
`endif

    // Codec clocks come straight off counter flops, so they never glitch.
    assign LRCLK   = r_cnt[9];
    assign SCLK    = r_cnt[4];
    assign MCLK    = r_cnt[1];
    assign RSTn    = r_rstn;
    assign SDin    = r_tx_shft[31];
    assign lft_out = r_lft;
    assign rht_out = r_rht;
    assign valid   = r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_frm_nxt   = r_frm;
        case (r_state)
            // A wrap seen in the one-clk RESET state still counts toward the codec reset.
            S_RESET, S_CODEC_RST: begin
                w_state_nxt = S_CODEC_RST;
                if (w_wrap) begin
                    if (r_frm == FW'(RSTN_FRAMES - 1)) begin
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_frm_nxt = r_frm + FW'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (w_wrap) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
            r_frm   <= '0;
            r_rstn  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_frm   <= w_frm_nxt;
            r_rstn  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_RST;
        end else begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Word is complete at cnt 0x010: its last bit was taken on the 0x00F rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shft <= '0;
            r_lft     <= '0;
            r_rht     <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_sclk_rise) begin
                r_rx_shft <= {r_rx_shft[30:0], w_rx_bit};
            end
            if (w_capture) begin
                r_lft <= r_rx_shft[31:16];
                r_rht <= r_rx_shft[15:0];
            end
            r_valid <= w_capture && (r_state == S_RUN);
        end
    end

    // Load lands on the 0x01F fall so the MSB sits behind the I2S one-bit delay slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shft <= '0;
        end else if (w_tx_load) begin
            r_tx_shft <= {lft_in, rht_in};
        end else if (w_sclk_fall) begin
            r_tx_shft <= {r_tx_shft[30:0], 1'b0};
        end
    end

endmodule
